// File: rtl/ipsc_scheduler.sv
// -----------------------------------------------------------------------------
// ipsc_scheduler
//
// Time-multiplexes one shared IPSC datapath across a neuron array, once per
// integration step. For each neuron the block reads Vmem/gex/gin from the
// neuron state RAMs, drives the datapath with the excitatory operands, then the
// inhibitory operands, and writes the summed synaptic current (Iex + Iinh) back.
// The datapath is combinational and slow. Each evaluation therefore has
// SETTLE_CYCLES cycles to settle (a multicycle path). The operand registers do
// not change during that window.
//
// Per-neuron sequence: FETCH, LOAD, EXC_WAIT x S, INH_WAIT x S, WRITE.
// This takes 2*S+3 cycles. A pass takes NumNeurons*(2*S+3)+1 cycles from the
// Start edge to the Done pulse.
//
// Ports:
//   Clock       sole clock, rising edge
//   Reset       asynchronous, active-low; clears all state and outputs
//   Start       pulse; begins a pass, only honoured in IDLE
//   NumNeurons  neurons to process, latched at Start (0 -> immediate Done)
//   Eex, Einh   signed reversal potentials, sampled when driven onto UnitE
//   StateAddr   read address to the Vmem/gex/gin RAMs (1-cycle read latency)
//   VmemIn      Vmem read data
//   GexIn       gex read data
//   GinIn       gin read data
//   UnitE       registered reversal-potential operand to the datapath
//   UnitVmem    registered Vmem operand to the datapath
//   UnitG       registered conductance operand to the datapath
//   UnitIPSC    combinational datapath result
//   IPSCWrEn    one-cycle write strobe
//   IPSCWrAddr  write address for the current neuron
//   IPSCWrData  Iex + Iinh (two's complement, wraps, no saturation)
//   Busy        high while a neuron is being processed (FETCH..WRITE)
//   Done        one-cycle pulse at the end of a pass
//
// SETTLE_CYCLES must be at least 1.
// -----------------------------------------------------------------------------
module ipsc_scheduler #(
  parameter int INTEGER_WIDTH     = 32,
  parameter int DATA_WIDTH_FRAC   = 32,
  parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int NEURON_ADDR_WIDTH = 8,
  parameter int SETTLE_CYCLES     = 2
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic [NEURON_ADDR_WIDTH-1:0] NumNeurons,
  input  logic [INTEGER_WIDTH-1:0]     Eex,
  input  logic [INTEGER_WIDTH-1:0]     Einh,
  output logic [NEURON_ADDR_WIDTH-1:0] StateAddr,
  input  logic [DATA_WIDTH-1:0]        VmemIn,
  input  logic [DATA_WIDTH-1:0]        GexIn,
  input  logic [DATA_WIDTH-1:0]        GinIn,
  output logic [INTEGER_WIDTH-1:0]     UnitE,
  output logic [DATA_WIDTH-1:0]        UnitVmem,
  output logic [DATA_WIDTH-1:0]        UnitG,
  input  logic [DATA_WIDTH-1:0]        UnitIPSC,
  output logic                         IPSCWrEn,
  output logic [NEURON_ADDR_WIDTH-1:0] IPSCWrAddr,
  output logic [DATA_WIDTH-1:0]        IPSCWrData,
  output logic                         Busy,
  output logic                         Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXC_WAIT,
    S_INH_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  // The settle counter counts down from SETTLE_CYCLES-1 to 0.
  // The capture happens on the edge where it reads 0.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t                         state;
  state_t                         next_state;
  logic [NEURON_ADDR_WIDTH-1:0]   idx;
  logic [NEURON_ADDR_WIDTH-1:0]   num_q;
  logic [CNT_W-1:0]               settle_cnt;
  logic [DATA_WIDTH-1:0]          gin_hold;
  logic [DATA_WIDTH-1:0]          acc;
  logic                           settle_done;
  logic                           last_neuron;

  // The index counter is the RAM read address. It only advances in WRITE,
  // so the address is stable through FETCH and LOAD.
  assign StateAddr   = idx;
  assign settle_done = (settle_cnt == '0);
  // num_q is never 0 while a neuron is in flight, so the subtraction cannot
  // underflow.
  assign last_neuron = (idx == num_q - 1'b1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: next_state gets a default before the case so that no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (Start) begin
          next_state = (NumNeurons != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH:    next_state = S_LOAD;
      S_LOAD:     next_state = S_EXC_WAIT;
      S_EXC_WAIT: if (settle_done) next_state = S_INH_WAIT;
      S_INH_WAIT: if (settle_done) next_state = S_WRITE;
      S_WRITE:    next_state = last_neuron ? S_DONE : S_FETCH;
      S_DONE:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath sequencing, operand registers and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      idx        <= '0;
      num_q      <= '0;
      settle_cnt <= '0;
      gin_hold   <= '0;
      acc        <= '0;
      UnitE      <= '0;
      UnitVmem   <= '0;
      UnitG      <= '0;
      IPSCWrEn   <= 1'b0;
      IPSCWrAddr <= '0;
      IPSCWrData <= '0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      // Busy and Done are registered from the next state. Both therefore
      // line up exactly with the state they describe.
      Busy     <= (next_state inside {S_FETCH, S_LOAD, S_EXC_WAIT,
                                      S_INH_WAIT, S_WRITE});
      Done     <= (next_state == S_DONE);
      IPSCWrEn <= 1'b0;

      case (state)
        S_IDLE: begin
          if (Start) begin
            num_q <= NumNeurons;
            idx   <= '0;
          end
        end

        S_LOAD: begin
          // RAM data is valid this cycle. Start the excitatory evaluation
          // and keep gin for the inhibitory evaluation.
          UnitE      <= Eex;
          UnitVmem   <= VmemIn;
          UnitG      <= GexIn;
          gin_hold   <= GinIn;
          settle_cnt <= SETTLE_LOAD;
        end

        S_EXC_WAIT: begin
          if (settle_done) begin
            acc        <= UnitIPSC;
            UnitE      <= Einh;
            UnitG      <= gin_hold;
            settle_cnt <= SETTLE_LOAD;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        S_INH_WAIT: begin
          if (settle_done) begin
            IPSCWrData <= acc + UnitIPSC;
            IPSCWrAddr <= idx;
            IPSCWrEn   <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end

        S_WRITE: begin
          // On the last neuron the index holds, so it never wraps even when
          // NumNeurons is at its maximum.
          if (!last_neuron) begin
            idx <= idx + 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipsc_scheduler.sv
// -----------------------------------------------------------------------------
// tb_ipsc_scheduler
//
// Bench for ipsc_scheduler.
// The neuron state RAMs are modelled as arrays with a 1-cycle read latency.
// The datapath is a stub: UnitG>>>1 in normal mode, or UnitG itself in
// identity mode (identity is used for the wrap case).
// The reference model works per pass from the block's timing rules. Neuron i
// writes in cycle (i+1)*(2S+3) after the Start edge. Done comes in cycle
// N*(2S+3)+1. The written data is stub(gex)+stub(gin).
// -----------------------------------------------------------------------------
module tb_ipsc_scheduler;

  localparam int IW  = 32;
  localparam int FW  = 32;
  localparam int DW  = IW + FW;
  localparam int AW  = 8;
  localparam int SC  = 2;
  localparam int PER = 2 * SC + 3;

  logic          Clock;
  logic          Reset;
  logic          Start;
  logic [AW-1:0] NumNeurons;
  logic [IW-1:0] Eex;
  logic [IW-1:0] Einh;
  logic [AW-1:0] StateAddr;
  logic [DW-1:0] VmemIn;
  logic [DW-1:0] GexIn;
  logic [DW-1:0] GinIn;
  logic [IW-1:0] UnitE;
  logic [DW-1:0] UnitVmem;
  logic [DW-1:0] UnitG;
  logic [DW-1:0] UnitIPSC;
  logic          IPSCWrEn;
  logic [AW-1:0] IPSCWrAddr;
  logic [DW-1:0] IPSCWrData;
  logic          Busy;
  logic          Done;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] vmem_mem [256];
  logic [DW-1:0] gex_mem  [256];
  logic [DW-1:0] gin_mem  [256];
  logic          stub_mode;
  logic signed [DW-1:0] half_g;
  logic [DW-1:0] last_wr_data;

  ipsc_scheduler #(
    .INTEGER_WIDTH    (IW),
    .DATA_WIDTH_FRAC  (FW),
    .DATA_WIDTH       (DW),
    .NEURON_ADDR_WIDTH(AW),
    .SETTLE_CYCLES    (SC)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .NumNeurons(NumNeurons),
    .Eex       (Eex),
    .Einh      (Einh),
    .StateAddr (StateAddr),
    .VmemIn    (VmemIn),
    .GexIn     (GexIn),
    .GinIn     (GinIn),
    .UnitE     (UnitE),
    .UnitVmem  (UnitVmem),
    .UnitG     (UnitG),
    .UnitIPSC  (UnitIPSC),
    .IPSCWrEn  (IPSCWrEn),
    .IPSCWrAddr(IPSCWrAddr),
    .IPSCWrData(IPSCWrData),
    .Busy      (Busy),
    .Done      (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // State RAMs with a 1-cycle read latency.
  always @(posedge Clock) begin
    VmemIn <= vmem_mem[StateAddr];
    GexIn  <= gex_mem[StateAddr];
    GinIn  <= gin_mem[StateAddr];
  end

  // Datapath stub.
  assign half_g   = $signed(UnitG) >>> 1;
  assign UnitIPSC = stub_mode ? UnitG : half_g;

  function automatic logic [DW-1:0] model_unit(input logic [DW-1:0] g);
    logic signed [DW-1:0] s;
    s = g;
    if (stub_mode) return g;
    return s >>> 1;
  endfunction

  task automatic fill_random(input int n);
    for (int k = 0; k < n; k++) begin
      vmem_mem[k] = {$urandom, $urandom};
      gex_mem[k]  = {$urandom, $urandom};
      gin_mem[k]  = {$urandom, $urandom};
    end
  endtask

  // Runs one pass of n neurons and checks it cycle by cycle.
  // repulse:   re-pulses Start in cycle 5 and again in the Done cycle.
  // abort_cyc: if non-zero, Reset is pulled low in that cycle.
  task automatic run_pass(input int n, input bit repulse, input int abort_cyc);
    int exp_done_cyc;
    int limit;
    int writes_seen;
    int exp_writes;
    int i;
    int p;
    bit in_pass;
    bit exp_wr;
    bit exp_dn;
    bit exp_busy;
    logic [DW-1:0] exp_data;

    exp_done_cyc = n * PER + 1;
    limit        = (abort_cyc > 0) ? abort_cyc + 8 : exp_done_cyc + 6;
    exp_writes   = (abort_cyc > 0) ? (abort_cyc - 1) / PER : n;
    if (exp_writes > n) exp_writes = n;
    writes_seen  = 0;

    @(negedge Clock);
    Start      = 1'b1;
    NumNeurons = AW'(n);
    @(negedge Clock);
    Start      = 1'b0;
    NumNeurons = AW'($urandom);  // must have no effect mid-pass

    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (cyc > 1) @(negedge Clock);
      Start = (repulse && (cyc == 5 || cyc == exp_done_cyc)) ? 1'b1 : 1'b0;
      if (abort_cyc > 0 && cyc == abort_cyc)     Reset = 1'b0;
      if (abort_cyc > 0 && cyc == abort_cyc + 3) Reset = 1'b1;
      #1;

      in_pass  = (abort_cyc == 0) || (cyc < abort_cyc);
      exp_wr   = in_pass && (cyc % PER == 0) && (cyc / PER >= 1) && (cyc / PER <= n);
      exp_dn   = in_pass && (cyc == exp_done_cyc);
      exp_busy = in_pass && (cyc <= n * PER);

      checks++;
      if (IPSCWrEn !== exp_wr) begin
        failures++;
        $display("FAIL wren n=%0d cyc=%0d got=%b exp=%b", n, cyc, IPSCWrEn, exp_wr);
      end
      checks++;
      if (Done !== exp_dn) begin
        failures++;
        $display("FAIL done n=%0d cyc=%0d got=%b exp=%b", n, cyc, Done, exp_dn);
      end
      checks++;
      if (Busy !== exp_busy) begin
        failures++;
        $display("FAIL busy n=%0d cyc=%0d got=%b exp=%b", n, cyc, Busy, exp_busy);
      end

      if (IPSCWrEn === 1'b1) begin
        writes_seen++;
        last_wr_data = IPSCWrData;
      end

      if (exp_wr) begin
        i = cyc / PER - 1;
        exp_data = model_unit(gex_mem[i]) + model_unit(gin_mem[i]);
        checks++;
        if (IPSCWrAddr !== AW'(i)) begin
          failures++;
          $display("FAIL wraddr cyc=%0d got=%0d exp=%0d", cyc, IPSCWrAddr, i);
        end
        checks++;
        if (IPSCWrData !== exp_data) begin
          failures++;
          $display("FAIL wrdata addr=%0d got=%h exp=%h", i, IPSCWrData, exp_data);
        end
      end

      if (in_pass && cyc <= n * PER) begin
        i = (cyc - 1) / PER;
        p = (cyc - 1) % PER;
        if (p == 2 || p == 3) begin
          checks++;
          if (UnitE !== Eex || UnitG !== gex_mem[i]) begin
            failures++;
            $display("FAIL exc_operands n=%0d cyc=%0d got E=%h G=%h exp E=%h G=%h",
                     i, cyc, UnitE, UnitG, Eex, gex_mem[i]);
          end
        end
        if (p == 4 || p == 5) begin
          checks++;
          if (UnitE !== Einh || UnitG !== gin_mem[i]) begin
            failures++;
            $display("FAIL inh_operands n=%0d cyc=%0d got E=%h G=%h exp E=%h G=%h",
                     i, cyc, UnitE, UnitG, Einh, gin_mem[i]);
          end
        end
        if (p >= 2 && p <= 5) begin
          checks++;
          if (UnitVmem !== vmem_mem[i]) begin
            failures++;
            $display("FAIL vmem_operand n=%0d cyc=%0d got=%h exp=%h",
                     i, cyc, UnitVmem, vmem_mem[i]);
          end
        end
      end

      if (abort_cyc > 0 && cyc >= abort_cyc && cyc < abort_cyc + 3) begin
        checks++;
        if (UnitE !== '0 || UnitG !== '0 || UnitVmem !== '0 || IPSCWrData !== '0 ||
            IPSCWrAddr !== '0 || StateAddr !== '0) begin
          failures++;
          $display("FAIL abort_clear cyc=%0d got E=%h G=%h V=%h D=%h A=%0d S=%0d exp all 0",
                   cyc, UnitE, UnitG, UnitVmem, IPSCWrData, IPSCWrAddr, StateAddr);
        end
      end
    end

    checks++;
    if (writes_seen !== exp_writes) begin
      failures++;
      $display("FAIL write_count n=%0d got=%0d exp=%0d", n, writes_seen, exp_writes);
    end
  endtask

  task automatic test_reset;
    Reset      = 1'b0;
    Start      = 1'b1;
    NumNeurons = 8'd3;
    repeat (3) @(negedge Clock);
    checks++;
    if ({Busy, Done, IPSCWrEn} !== 3'b000 || StateAddr !== '0 || IPSCWrAddr !== '0 ||
        UnitE !== '0 || UnitG !== '0 || UnitVmem !== '0 || IPSCWrData !== '0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b wren=%b sa=%0d E=%h G=%h V=%h D=%h exp all 0",
               Busy, Done, IPSCWrEn, StateAddr, UnitE, UnitG, UnitVmem, IPSCWrData);
    end
    Start = 1'b0;
    Reset = 1'b1;
    repeat (3) begin
      @(negedge Clock);
      checks++;
      if (Busy !== 1'b0 || IPSCWrEn !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset got busy=%b wren=%b exp 0", Busy, IPSCWrEn);
      end
    end
    fill_random(3);
    run_pass(3, 1'b0, 0);
  endtask

  task automatic test_basic_pass;
    stub_mode = 1'b0;
    Eex  = 32'h0000_0000;
    Einh = 32'hFFFF_FFB0;  // -80
    fill_random(3);
    run_pass(3, 1'b0, 0);
  endtask

  task automatic test_zero_neurons;
    run_pass(0, 1'b0, 0);
  endtask

  task automatic test_start_ignored;
    fill_random(3);
    run_pass(3, 1'b1, 0);
  endtask

  task automatic test_reset_mid_pass;
    fill_random(3);
    run_pass(3, 1'b0, 10);
    fill_random(3);
    run_pass(3, 1'b0, 0);
  endtask

  task automatic test_wrap;
    stub_mode   = 1'b1;
    gex_mem[0]  = 64'h7FFF_FFFF_FFFF_FFFF;
    gin_mem[0]  = 64'h0000_0000_0000_0001;
    vmem_mem[0] = {$urandom, $urandom};
    last_wr_data = '0;
    run_pass(1, 1'b0, 0);
    checks++;
    if (last_wr_data !== 64'h8000_0000_0000_0000) begin
      failures++;
      $display("FAIL wrap got=%h exp=8000000000000000", last_wr_data);
    end
    stub_mode = 1'b0;
  endtask

  task automatic test_random;
    int n;
    for (int r = 0; r < 5; r++) begin
      n         = $urandom_range(1, 6);
      stub_mode = $urandom_range(0, 1) == 1;
      Eex       = $urandom;
      Einh      = $urandom;
      fill_random(n);
      run_pass(n, 1'b0, 0);
    end
    stub_mode = 1'b0;
  endtask

  task automatic test_max_neurons;
    Eex  = $urandom;
    Einh = $urandom;
    fill_random(255);
    run_pass(255, 1'b0, 0);
  endtask

  initial begin
    Reset      = 1'b0;
    Start      = 1'b0;
    NumNeurons = '0;
    Eex        = '0;
    Einh       = 32'hFFFF_FFB0;
    stub_mode  = 1'b0;
    last_wr_data = '0;
    for (int k = 0; k < 256; k++) begin
      vmem_mem[k] = '0;
      gex_mem[k]  = '0;
      gin_mem[k]  = '0;
    end

    test_reset();
    test_basic_pass();
    test_zero_neurons();
    test_start_ignored();
    test_reset_mid_pass();
    test_wrap();
    test_random();
    test_max_neurons();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
